// File: rtl/pipe_hazard_ctl.sv
// pipe_hazard_ctl: stall/flush sequencer for the 5-stage pipeline with memory handshake, timeout and perf counters
module pipe_hazard_ctl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_memRead,
  input  logic             i_ex_branch_taken,
  input  logic             i_mem_op,
  input  logic             i_dmem_ready,
  output logic             o_dmem_req,
  output logic             o_pc_we,
  output logic             o_ifid_we,
  output logic             o_idex_we,
  output logic             o_exmem_we,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_memwb_bubble,
  output logic             o_err,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count
);
  localparam int WW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ADV, S_ERR} state_t;
  state_t           r_state, w_next;
  logic [WW-1:0]    r_wcnt;
  logic             r_err;
  logic [CNT_W-1:0] r_stall, r_flush;
  logic             w_freeze, w_lu;
  // Next state plus all control outputs; the memory freeze outranks branch, which outranks load-use
  always_comb begin
    w_lu = i_ex_memRead && i_ex_rd != 5'd0 &&
           ((i_id_use_rs1 && i_id_rs1 == i_ex_rd) || (i_id_use_rs2 && i_id_rs2 == i_ex_rd));
    w_next = r_state;
    w_freeze = 1'b0;
    o_dmem_req = 1'b0;
    case (r_state)
      S_RUN: if (i_mem_op) begin
        o_dmem_req = 1'b1;
        w_freeze = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        w_freeze = 1'b1;
        w_next = i_dmem_ready ? S_ADV : (r_wcnt == WW'(TIMEOUT - 1)) ? S_ERR : S_WAIT;
      end
      S_ADV: w_next = S_RUN;
      default: w_freeze = 1'b1;
    endcase
    o_pc_we = !w_freeze && (i_ex_branch_taken || !w_lu);
    o_ifid_we = o_pc_we;
    o_idex_we = !w_freeze;
    o_exmem_we = !w_freeze;
    o_ifid_flush = !w_freeze && i_ex_branch_taken;
    o_idex_flush = !w_freeze && (i_ex_branch_taken || w_lu);
    o_memwb_bubble = w_freeze;
  end
  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_RUN;
    else r_state <= w_next;
  end
  // Wait counter: zero outside WAIT so every WAIT entry starts from 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wcnt <= '0;
    else r_wcnt <= (r_state == S_WAIT && w_next == S_WAIT) ? r_wcnt + 1'b1 : '0;
  end
  // Sticky timeout flag, set on the edge that enters ERR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else r_err <= r_err | (w_next == S_ERR);
  end
  // Saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      if (!o_pc_we && r_stall != '1) r_stall <= r_stall + 1'b1;
      if (o_ifid_flush && r_flush != '1) r_flush <= r_flush + 1'b1;
    end
  end
  assign o_err = r_err;
  assign o_stall_cycles = r_stall;
  assign o_flush_count = r_flush;
endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// tb_pipe_hazard_ctl: table vectors, corner sequences and random checking against a transaction-level model
module tb_pipe_hazard_ctl;
  localparam int TO = 4;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic u1 = 0, u2 = 0, mr = 0, br = 0, mo = 0, rdy = 0;
  logic req, pcwe, ifidwe, idexwe, exmemwe, ifidfl, idexfl, bub, err;
  logic [CW-1:0] stall, flc;
  logic [7:0] outv;
  int checks = 0, errors = 0;
  assign outv = {pcwe, ifidwe, idexwe, exmemwe, ifidfl, idexfl, bub, req};
  always #5 clk = ~clk;
  pipe_hazard_ctl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(u1), .i_id_use_rs2(u2),
    .i_ex_rd(rd), .i_ex_memRead(mr), .i_ex_branch_taken(br), .i_mem_op(mo), .i_dmem_ready(rdy),
    .o_dmem_req(req), .o_pc_we(pcwe), .o_ifid_we(ifidwe), .o_idex_we(idexwe), .o_exmem_we(exmemwe),
    .o_ifid_flush(ifidfl), .o_idex_flush(idexfl), .o_memwb_bubble(bub), .o_err(err),
    .o_stall_cycles(stall), .o_flush_count(flc));
  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, mr, br, mo;
    logic [7:0] ex;
  } vec_t;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic idle();
    rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; mr = 0; br = 0; mo = 0; rdy = 0;
  endtask
  task automatic rst_dut();
    @(posedge clk); #1;
    idle();
    rst = 1'b0; #1; rst = 1'b1;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  vec_t tbl[10];
  initial begin
    int reqs;
    bit busy, done, dead, issue, frz, lu;
    int waited, m_st, m_fl;
    logic [7:0] ex;
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 8'b1111_0000};
    tbl[1] = '{3, 0, 3, 1, 0, 1, 0, 0, 8'b0011_0100};
    tbl[2] = '{0, 3, 3, 0, 0, 1, 0, 0, 8'b1111_0000};
    tbl[3] = '{0, 0, 0, 1, 1, 1, 0, 0, 8'b1111_0000};
    tbl[4] = '{7, 0, 7, 1, 0, 0, 0, 0, 8'b1111_0000};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 1, 0, 8'b1111_1100};
    tbl[6] = '{2, 0, 2, 1, 0, 1, 1, 0, 8'b1111_1100};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 1, 8'b0000_0011};
    tbl[8] = '{2, 0, 2, 1, 0, 1, 1, 1, 8'b0000_0011};
    tbl[9] = '{1, 9, 9, 0, 1, 1, 0, 0, 8'b0011_0100};
    rst_dut();
    @(negedge clk);
    chk("reset_out", outv, 8'b1111_0000);
    chk("reset_err", err, 0);
    chk("reset_stall", stall, 0);
    chk("reset_flush", flc, 0);
    for (int i = 0; i < 10; i++) begin
      rst_dut();
      rs1 = tbl[i].rs1; rs2 = tbl[i].rs2; rd = tbl[i].rd; u1 = tbl[i].u1; u2 = tbl[i].u2;
      mr = tbl[i].mr; br = tbl[i].br; mo = tbl[i].mo;
      @(negedge clk);
      chk($sformatf("table_%0d", i), outv, tbl[i].ex);
    end
    // load-use single bubble, then rd=0 does not stall
    rst_dut();
    mr = 1; rd = 5; rs2 = 5; u2 = 1;
    @(negedge clk);
    chk("lu_out", outv, 8'b0011_0100);
    tick(); idle();
    @(negedge clk);
    chk("lu_stall1", stall, 1);
    mr = 1; rd = 0; rs2 = 0; u2 = 1;
    @(negedge clk);
    chk("lu_rd0_pcwe", pcwe, 1);
    tick();
    @(negedge clk);
    chk("lu_rd0_stall", stall, 1);
    // branch outranks load-use
    rst_dut();
    br = 1; mr = 1; rd = 4; rs1 = 4; u1 = 1;
    @(negedge clk);
    chk("br_lu_out", outv, 8'b1111_1100);
    tick(); idle();
    @(negedge clk);
    chk("br_lu_flush", flc, 1);
    chk("br_lu_stall", stall, 0);
    // memory op with ready on the third WAIT cycle
    rst_dut();
    mo = 1; reqs = 0;
    for (int c = 0; c < 4; c++) begin
      rdy = (c == 3);
      @(negedge clk);
      reqs += int'(req);
      chk($sformatf("mem_req_%0d", c), req, c == 0);
      chk($sformatf("mem_frz_%0d", c), outv[7:1], 7'b0000_001);
      tick();
    end
    rdy = 0;
    @(negedge clk);
    reqs += int'(req);
    chk("mem_adv_out", outv, 8'b1111_0000);
    tick();
    mo = 0; rdy = 1;
    @(negedge clk);
    chk("mem_reqs", reqs, 1);
    chk("mem_stall", stall, 4);
    tick(); rdy = 0;
    @(negedge clk);
    chk("mem_rdy_ignored", outv, 8'b1111_0000);
    // timeout, sticky err, async reset
    rst_dut();
    mo = 1;
    tick();
    mo = 0;
    for (int c = 0; c < TO; c++) begin
      @(negedge clk);
      chk($sformatf("to_wait_err_%0d", c), err, 0);
      tick();
    end
    @(negedge clk);
    chk("to_err", err, 1);
    chk("to_frz", outv, 8'b0000_0010);
    rdy = 1;
    tick(); tick();
    @(negedge clk);
    chk("to_err_sticky", err, 1);
    chk("to_frz_sticky", pcwe, 0);
    rdy = 0; rst = 0; #1;
    chk("to_rst_err", err, 0);
    chk("to_rst_stall", stall, 0);
    chk("to_rst_out", outv, 8'b1111_0000);
    rst = 1;
    // branch held through a memory stall flushes once, in ADV
    rst_dut();
    mo = 1; br = 1;
    @(negedge clk);
    chk("brm_run", outv, 8'b0000_0011);
    tick(); rdy = 1;
    @(negedge clk);
    chk("brm_wait", outv, 8'b0000_0010);
    tick(); rdy = 0;
    @(negedge clk);
    chk("brm_adv", outv, 8'b1111_1100);
    tick(); idle();
    @(negedge clk);
    chk("brm_flush", flc, 1);
    // stall counter saturation
    rst_dut();
    mr = 1; rd = 6; rs1 = 6; u1 = 1;
    repeat (20) tick();
    @(negedge clk);
    chk("sat_stall", stall, MAXC);
    // random stimulus against a transaction-level model
    rst_dut();
    busy = 0; done = 0; dead = 0; waited = 0; m_st = 0; m_fl = 0;
    for (int i = 0; i < 3000; i++) begin
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
      u1 = $urandom_range(0, 1) == 1; u2 = $urandom_range(0, 1) == 1;
      mr = $urandom_range(0, 9) < 4; br = $urandom_range(0, 9) < 2;
      mo = $urandom_range(0, 9) < 3; rdy = $urandom_range(0, 9) < 4;
      issue = !busy && !dead && !done && mo;
      frz = dead || busy || issue;
      lu = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      ex = frz ? {7'b0000_001, issue} : br ? 8'b1111_1100 : lu ? 8'b0011_0100 : 8'b1111_0000;
      @(negedge clk);
      chk("rnd_out", outv, ex);
      chk("rnd_err", err, dead);
      chk("rnd_stall", stall, m_st);
      chk("rnd_flush", flc, m_fl);
      if (!ex[7] && m_st < MAXC) m_st++;
      if (!frz && br && m_fl < MAXC) m_fl++;
      if (dead) ;
      else if (busy) begin
        if (rdy) begin busy = 0; done = 1; end
        else if (++waited == TO) begin busy = 0; dead = 1; end
      end else if (issue) begin busy = 1; waited = 0; end
      else done = 0;
      tick();
      if ((dead && $urandom_range(0, 3) == 0) || $urandom_range(0, 59) == 0) begin
        rst = 0; #1; rst = 1;
        busy = 0; done = 0; dead = 0; waited = 0; m_st = 0; m_fl = 0;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctl.md
# pipe_hazard_ctl

Central stall/flush sequencer for the 5-stage pipeline. Drives write-enable and flush/bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB control-pipeline registers. Handles three events: load-use hazards, taken branches resolved in EX, and a variable-latency data-memory handshake. Also owns a memory-timeout error flag and two saturating performance counters.

## Interface
Parameters:
- TIMEOUT, 64: maximum cycles spent in WAIT before error (≥2)
- CNT_W, 16: width of the performance counters

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  the ID instruction actually reads rs1 / rs2
- ex_rd  in  5  destination register in EX
- ex_memRead  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX redirects the PC (pcSel)
- mem_op  in  1  MEM instruction is a load or store (memRead|memWrite)
- dmem_ready  in  1  data memory completion pulse
- dmem_req  out  1  one-cycle request pulse to data memory
- pc_we, ifid_we, idex_we, exmem_we  out  1  register write enables
- ifid_flush, idex_flush  out  1  clear the register (insert a bubble)
- memwb_bubble  out  1  MEM/WB captures a bubble (regWrite/memWrite zeroed)
- err  out  1  sticky memory timeout
- stall_cycles  out  CNT_W  cycles with pc_we=0
- flush_count  out  CNT_W  branch flushes applied

## Operation
- FSM states: RUN, WAIT, ADV, ERR. Reset state is RUN.
- RUN:
  - If mem_op: dmem_req=1 and freeze (see below); next state is WAIT.
  - Otherwise: hazard logic applies; stay in RUN.
- WAIT:
  - Freeze. dmem_ready is sampled only in this state.
  - If dmem_ready: go to ADV.
  - Else if the wait counter reaches TIMEOUT-1: go to ERR.
- ADV:
  - Release the pipeline (the MEM instruction's result enters MEM/WB).
  - Hazard logic applies. No new request is issued even if mem_op is set.
  - Next state is RUN.
- ERR: freeze; err=1. Exit only through reset.
- Freeze: pc_we=ifid_we=idex_we=exmem_we=0, memwb_bubble=1, all flushes 0.
- Hazard logic, in priority order:
  1. ex_branch_taken → pc_we=1, ifid_flush=1, idex_flush=1; flush_count+1.
  2. Load-use → pc_we=0, ifid_we=0, idex_flush=1; other enables 1.
     - Condition: ex_memRead && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
  3. Otherwise all we=1, flushes 0, memwb_bubble=0.
- The memory stall outranks both hazards. A branch or load-use event held during a freeze is re-evaluated when the freeze ends, because ID/EX is frozen and its inputs stay stable.
- The wait counter clears on entry to WAIT and is ceil(log2(TIMEOUT)) bits wide.
- stall_cycles and flush_count saturate at all-ones and never wrap.
- Reset values: state RUN, err=0, both counters 0, wait counter 0. With idle inputs in RUN: all we=1, flushes 0, memwb_bubble=0, dmem_req=0.

## Timing
- All control outputs are combinational from the state and the current inputs. State, counters and err are registered on posedge clk.
- Memory op with ready on the first WAIT cycle:
  - Cycle 0 (RUN): req and freeze.
  - Cycle 1 (WAIT): ready seen, freeze.
  - Cycle 2 (ADV): advance.
  - Minimum cost is 2 stall cycles. Each extra WAIT cycle adds 1.
- dmem_req is high for exactly one cycle per memory operation. Back-to-back memory ops are separated by the ADV cycle.
- dmem_ready asserted while in RUN or ADV is ignored.
- Timeout: ERR is entered after TIMEOUT cycles in WAIT without ready. err rises on the next clock edge.
- Load-use costs exactly 1 bubble cycle. A taken branch costs 2 squashed instructions.
- Async reset mid-WAIT: immediate return to RUN with counters and err cleared. An outstanding memory response is then ignored.
- Counters update on the same edge as the state.

## Test plan
- Load-use: ex_memRead=1, ex_rd=5, id_rs2=5, id_use_rs2=1 → one cycle with pc_we=0, ifid_we=0, idex_flush=1; stall_cycles=1. Repeat with ex_rd=0 → no stall.
- Branch vs load-use the same cycle: ex_branch_taken=1 and a load-use match → pc_we=1, ifid_flush=1, idex_flush=1, flush_count=1.
- Memory op, ready after 3 WAIT cycles → dmem_req pulses once; freeze for 4 cycles, then ADV releases; stall_cycles=4; back to RUN.
- Timeout with TIMEOUT=4 and ready never asserted → err=1 after 4 WAIT cycles; freeze persists; a later dmem_ready has no effect; rst low clears err and returns to RUN.
- Branch during a memory stall: mem_op and ex_branch_taken both set → freeze until ADV, then flush in ADV; flush_count increments exactly once.
- Saturation with CNT_W=4: 20 load-use stalls → stall_cycles holds at 15.
